// File: rtl/svc_rv_ext_md.sv
// RV32/64 M-extension multiply/divide unit, one operation in flight.
// Latency: MUL* = MUL_STAGES cycles; DIV* = XLEN+1 cycles (1 on div-by-zero / signed overflow).
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
//
// Ports: clk, rst_n (sync, active-low), flush,
//        in_valid/in_ready/in_op/in_rs1/in_rs2 (request),
//        out_valid/out_ready/out_result/out_illegal (response).
// Build option: define SVC_RV_EXT_MD_DIV_EN to include the divider; without it
// ops 4-7 complete in one cycle flagged illegal (Zmmul behaviour).
module svc_rv_ext_md #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_illegal
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CW = $clog2(XLEN + 1) + 1;

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_r;
    // a_r/b_r hold the multiply operands, or dividend-shifting-to-quotient
    // and divisor magnitude while dividing.
    logic [XLEN-1:0] a_r;
    logic [XLEN-1:0] b_r;
    logic [XLEN-1:0] res_r;
    logic            ill_r;

    // ---------------- multiplier ----------------
    // Operands are sign- or zero-extended to 2*XLEN+2 bits so a single
    // unsigned multiply yields the correct low bits for every signedness mix.
    logic                a_sgn;
    logic                b_sgn;
    logic [2*XLEN+1:0]   a_wide;
    logic [2*XLEN+1:0]   b_wide;
    logic [2*XLEN+1:0]   prod;
    logic [XLEN-1:0]     mul_res;

    always_comb begin
        a_sgn   = (op_r == 3'd1) || (op_r == 3'd2);
        b_sgn   = (op_r == 3'd1);
        a_wide  = {{(XLEN+2){a_sgn & a_r[XLEN-1]}}, a_r};
        b_wide  = {{(XLEN+2){b_sgn & b_r[XLEN-1]}}, b_r};
        prod    = a_wide * b_wide;
        mul_res = (op_r == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

`ifdef SVC_RV_EXT_MD_DIV_EN
    // ---------------- divider ----------------
    logic [XLEN-1:0] rem_r;
    logic            neg_q_r;
    logic            neg_r_r;
    logic            fast_r;

    // Request-side decode (evaluated on the accepting edge).
    logic            d_signed;
    logic            d_is_rem;
    logic            rs1_neg;
    logic            rs2_neg;
    logic [XLEN-1:0] dvd_mag;
    logic [XLEN-1:0] dsr_mag;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] fast_res;

    always_comb begin
        d_signed = ~in_op[0];
        d_is_rem = in_op[1];
        rs1_neg  = d_signed & in_rs1[XLEN-1];
        rs2_neg  = d_signed & in_rs2[XLEN-1];
        dvd_mag  = rs1_neg ? (~in_rs1 + 1'b1) : in_rs1;
        dsr_mag  = rs2_neg ? (~in_rs2 + 1'b1) : in_rs2;
        div_zero = (in_rs2 == '0);
        div_ovf  = d_signed && (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_rs2 == '1);
        if (div_zero)
            fast_res = d_is_rem ? in_rs1 : '1;
        else
            fast_res = d_is_rem ? '0 : in_rs1;
    end

    // One restoring step: shift in the next dividend bit, try subtracting.
    // Bit XLEN of the difference is the borrow (remainder < divisor always).
    logic [XLEN:0]   shl;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    always_comb begin
        shl   = {rem_r, a_r[XLEN-1]};
        diff  = shl - {1'b0, b_r};
        q_fix = neg_q_r ? (~a_r + 1'b1) : a_r;
        r_fix = neg_r_r ? (~rem_r + 1'b1) : rem_r;
    end
`endif

    // ---------------- control ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            op_r    <= '0;
            a_r     <= '0;
            b_r     <= '0;
            res_r   <= '0;
            ill_r   <= 1'b0;
`ifdef SVC_RV_EXT_MD_DIV_EN
            rem_r   <= '0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            fast_r  <= 1'b0;
`endif
        end else if (flush) begin
            // Flush wins over a same-cycle accept: the request is dropped.
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_r  <= in_op;
                        a_r   <= in_rs1;
                        b_r   <= in_rs2;
                        cnt   <= '0;
                        ill_r <= 1'b0;
                        if (!in_op[2]) begin
                            state <= S_MUL;
                        end else begin
                            state <= S_DIV;
`ifdef SVC_RV_EXT_MD_DIV_EN
                            a_r     <= dvd_mag;
                            b_r     <= dsr_mag;
                            rem_r   <= '0;
                            neg_q_r <= rs1_neg ^ rs2_neg;
                            neg_r_r <= rs1_neg;
                            fast_r  <= div_zero | div_ovf;
                            res_r   <= fast_res;
`else
                            res_r   <= '0;
                            ill_r   <= 1'b1;
`endif
                        end
                    end
                end
                S_MUL: begin
                    if (cnt == CW'(MUL_STAGES - 1)) begin
                        res_r <= mul_res;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DIV: begin
`ifdef SVC_RV_EXT_MD_DIV_EN
                    if (fast_r) begin
                        state <= S_DONE;
                    end else if (cnt == CW'(XLEN)) begin
                        // Sign fixup cycle after the last quotient bit.
                        res_r <= op_r[1] ? r_fix : q_fix;
                        state <= S_DONE;
                    end else begin
                        if (!diff[XLEN]) begin
                            rem_r <= diff[XLEN-1:0];
                            a_r   <= {a_r[XLEN-2:0], 1'b1};
                        end else begin
                            rem_r <= shl[XLEN-1:0];
                            a_r   <= {a_r[XLEN-2:0], 1'b0};
                        end
                        cnt <= cnt + 1'b1;
                    end
`else
                    state <= S_DONE;
`endif
                end
                default: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (state == S_IDLE) && rst_n;
    assign out_valid   = (state == S_DONE);
    assign out_result  = res_r;
    assign out_illegal = ill_r;

endmodule

// File: tb/tb_svc_rv_ext_md.sv
// Directed bench for svc_rv_ext_md (XLEN=32, MUL_STAGES=2).
// Latency measured in rising edges after the accepting edge.
// Divider checks follow the SVC_RV_EXT_MD_DIV_EN build setting.
module tb_svc_rv_ext_md;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    svc_rv_ext_md #(.XLEN(32), .MUL_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_illegal(out_illegal)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one request and wait (bounded) for out_valid.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input logic exp_ill);
        int lat;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        issue(op, a, b, lat);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_result"}, 64'(out_result), 64'(exp_res));
        check({tag, "_illegal"}, 64'(out_illegal), 64'(exp_ill));
        tick();
        check({tag, "_consumed"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int lat;
        int seen;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_rs1    = '0;
        in_rs2    = '0;
        out_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_illegal", 64'(out_illegal), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        tick();
        check("idle_in_ready", 64'(in_ready), 64'd1);

        // Multiplies
        run_op("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2, 1'b0);
        run_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2, 1'b0);
        run_op("mulh",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2, 1'b0);
        run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 2, 1'b0);

`ifdef SVC_RV_EXT_MD_DIV_EN
        // Iterative divides
        run_op("div",    3'd4, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA, 33, 1'b0);
        run_op("rem",    3'd6, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, 33, 1'b0);
        run_op("divu",   3'd5, 32'd100,      32'd7, 32'd14,       33, 1'b0);
        run_op("remu",   3'd7, 32'd100,      32'd7, 32'd2,        33, 1'b0);
        // Fast paths
        run_op("divu0",  3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 1'b0);
        run_op("remu0",  3'd7, 32'd5, 32'd0, 32'd5,        1, 1'b0);
        run_op("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0);
        run_op("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 1'b0);
`else
        run_op("div_ill", 3'd4, 32'd9, 32'd3, 32'd0, 1, 1'b1);
        run_op("remu_ill", 3'd7, 32'd100, 32'd7, 32'd0, 1, 1'b1);
        run_op("mul_after_ill", 3'd0, 32'd3, 32'd4, 32'd12, 2, 1'b0);
`endif

        // Response held under backpressure
        out_ready = 1'b0;
        issue(3'd0, 32'd5, 32'd6, lat);
        check("hold_latency", 64'(lat), 64'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_result", 64'(out_result), 64'd30);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        check("release_valid", 64'(out_valid), 64'd0);
        check("release_in_ready", 64'(in_ready), 64'd1);

        // Flush in the middle of an operation
`ifdef SVC_RV_EXT_MD_DIV_EN
        in_op = 3'd4; in_rs1 = 32'd1000; in_rs2 = 32'd7;
`else
        in_op = 3'd0; in_rs1 = 32'd1000; in_rs2 = 32'd7;
`endif
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
`ifdef SVC_RV_EXT_MD_DIV_EN
        repeat (9) tick();
`endif
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("flush_no_resp", 64'(seen), 64'd0);

        // Flush beats a simultaneous accept
        in_op = 3'd0; in_rs1 = 32'd2; in_rs2 = 32'd2;
        in_valid = 1'b1;
        flush = 1'b1;
        tick();
        in_valid = 1'b0;
        flush = 1'b0;
        check("flush_acc_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("flush_acc_no_resp", 64'(seen), 64'd0);

        // Reset in the middle of a multiply
        in_op = 3'd0; in_rs1 = 32'd9; in_rs2 = 32'd9;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        tick();
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_result", 64'(out_result), 64'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("midrst_no_resp", 64'(seen), 64'd0);
        run_op("mul_after_rst", 3'd0, 32'd3, 32'd4, 32'd12, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/svc_rv_ext_md.md
SVC_RV_EXT_MD -- requirements
Module: svc_rv_ext_md

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width (32 or 64).
REQ-002 SHALL have parameter MUL_STAGES, default 2, meaning multiply latency in cycles (1..4).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have port flush, input, 1, meaning kill any in-flight or held operation.
REQ-006 SHALL have ports in_valid input 1 and in_ready output 1, meaning the request handshake.
REQ-007 SHALL have port in_op, input, 3, meaning RV M funct3 (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
REQ-008 SHALL have ports in_rs1 and in_rs2, input, XLEN each, meaning the operands.
REQ-009 SHALL have ports out_valid output 1 and out_ready input 1, meaning the response handshake.
REQ-010 SHALL have port out_result, output, XLEN, meaning the operation result.
REQ-011 SHALL have port out_illegal, output, 1, meaning the op is not supported in this build.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, DONE; one operation in flight at a time.
REQ-013 SHALL drive in_ready=1 only in IDLE; accept when in_valid&in_ready at an edge, latching op and operands.
REQ-014 SHALL, on an accepted op 0-3, go IDLE->MUL, advance a stage counter, enter DONE exactly MUL_STAGES cycles after acceptance.
REQ-015 SHALL compute MUL as low XLEN bits; MULH/MULHSU/MULHU as high XLEN bits of the 2*XLEN product with signed*signed, signed*unsigned, unsigned*unsigned operands.
REQ-016 SHALL, on an accepted op 4-7 with rs2!=0 and not signed overflow, go IDLE->DIV and run a radix-2 restoring divide on magnitudes, one quotient bit per cycle, entering DONE XLEN+1 cycles after acceptance (XLEN iterations plus sign fixup).
REQ-017 SHALL apply RV sign rules: quotient negative iff operand signs differ (DIV); remainder takes the dividend sign (REM).
REQ-018 SHALL take a fast path for divide-by-zero, entering DONE 1 cycle after acceptance: quotient all ones, remainder = rs1.
REQ-019 SHALL take the fast path for DIV/REM with rs1=-2^(XLEN-1), rs2=-1: quotient = rs1, remainder 0.
REQ-020 SHALL assert out_valid only in DONE, holding out_result/out_illegal stable until out_valid&out_ready, then return to IDLE.
REQ-021 SHALL not accept a new request in the cycle the response is consumed (in_ready rises the following cycle).
REQ-022 SHALL, when flush=1 at an edge, go to IDLE from any state with no response produced; flush overrides a simultaneous accept (request dropped).
REQ-023 SHALL keep out_illegal=0 for every supported op.

Reset
REQ-024 SHALL, with rst_n=0 at an edge, enter IDLE, drive out_valid=0, out_result=0, out_illegal=0, clear stage/iteration counters; in_ready=0 while rst_n=0.
REQ-025 SHALL abandon any operation when reset asserts mid-operation, producing no response afterwards.

Configuration
REQ-026 SHALL compile the divider only when macro SVC_RV_EXT_MD_DIV_EN is defined.
REQ-027 SHALL, with SVC_RV_EXT_MD_DIV_EN defined, implement ops 4-7 per REQ-016..019.
REQ-028 SHALL, without SVC_RV_EXT_MD_DIV_EN, complete ops 4-7 one cycle after acceptance with out_result=0, out_illegal=1 and no divider logic (Zmmul behaviour); ops 0-3 unchanged.

Verification (XLEN=32, MUL_STAGES=2, DIV_EN defined unless stated)
REQ-029 SHALL cover MUL 7*0xFFFFFFFD -> 0xFFFFFFEB, out_valid 2 cycles after accept; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
REQ-030 SHALL cover DIV 0xFFFFFFEC/3 -> 0xFFFFFFFA and REM -> 0xFFFFFFFE, each out_valid 33 cycles after accept; DIVU 100/7 -> 14, REMU -> 2.
REQ-031 SHALL cover DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, each in 1 cycle.
REQ-032 SHALL cover out_ready held low 5 cycles in DONE -> out_valid and out_result stable, in_ready=0; release -> IDLE, in_ready=1 next cycle.
REQ-033 SHALL cover flush 10 cycles into a DIV, and rst_n low mid-MUL -> IDLE next cycle, no out_valid, next MUL 3*4 -> 12 correct.
REQ-034 SHALL cover build without SVC_RV_EXT_MD_DIV_EN: DIV 9/3 -> out_illegal=1, out_result=0 after 1 cycle; MUL 3*4 -> 12, out_illegal=0.
